// File: rtl/apb_master_pkg.sv
// Shared types and widths for the APB requester bridge.
// Provides the FSM state enum and the APB address/data widths.
package apb_master_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter with expiry compare.
// Ports: clk, rst (sync, high), clear, enable, pready -> expire.
module apb_timeout_cnt
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic pready,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !pready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires in the ACCESS cycle that would be the last allowed wait;
  // a ready completer in that same cycle takes priority.
  assign expire = enable && !pready && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: valid/ready command in, one APB transfer, valid/ready rsp out.
// Ports: pclk/preset, cmd_*, rsp_*, APB psel/penable/pwrite/paddr/pwdata/prdata/pready. Option: APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic [APB_DATA_W-1:0] pwdata,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pready
);

  state_e state_q, state_d;
  logic cmd_ready_q, cmd_ready_d;
  logic psel_q, psel_d;
  logic penable_q, penable_d;
  logic pwrite_q, pwrite_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic rsp_err_q, rsp_err_d;
  logic expire;

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk   (pclk),
    .rst   (preset),
    .clear (state_q == SETUP),
    .enable(state_q == ACCESS),
    .pready(pready),
    .expire(expire)
  );
`else
  wire unused_timeout = |TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          psel_d      = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready || expire) begin
          rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
          rsp_err_d   = !pready;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge.
// Drives and samples on the falling edge; timeout cases need APB_TIMEOUT_EN.
module tb_apb_master_bridge;

  logic       pclk = 1'b0;
  logic       preset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling
  // edge with the DUT idle again, so calls can run back to back.
  task automatic xfer(input logic       wr,
                      input logic [7:0] addr,
                      input logic [7:0] wdata,
                      input int         waits,
                      input int         acc_n,
                      input logic [7:0] rd_in,
                      input int         hold,
                      input logic [7:0] exp_rd,
                      input logic       exp_err,
                      input int         exp_lat);
    int lat;
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr;
    cmd_addr = addr; cmd_wdata = wdata;
    rsp_ready = 0; pready = 0; prdata = 8'hEE;
    @(negedge pclk);
    lat = 1;
    cmd_valid = 0; cmd_addr = 8'hFF; cmd_wdata = 8'hFF;
    chk("setup_psel", {psel, penable}, 2'b10);
    chk("setup_addr", paddr, addr);
    chk("setup_wdata", pwdata, wdata);
    chk("setup_write", pwrite, wr);
    for (int i = 0; i < acc_n; i++) begin
      @(negedge pclk);
      lat++;
      chk("access_sel", {psel, penable}, 2'b11);
      chk("access_addr", paddr, addr);
      chk("access_wdata", pwdata, wdata);
      chk("access_write", pwrite, wr);
      pready = (i == waits);
      prdata = (i == waits) ? rd_in : 8'hEE;
    end
    @(negedge pclk);
    lat++;
    pready = 0;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_latency", lat, exp_lat);
    chk("resp_rdata", rsp_rdata, exp_rd);
    chk("resp_err", rsp_err, exp_err);
    chk("resp_bus_idle", {psel, penable}, 2'b00);
    for (int j = 0; j < hold; j++) begin
      @(negedge pclk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", rsp_err, exp_err);
      chk("hold_ready_psel", {cmd_ready, psel}, 2'b00);
    end
    rsp_ready = 1;
    @(negedge pclk);
    rsp_ready = 0;
    chk("after_hs_valid", rsp_valid, 0);
  endtask

  initial begin
    preset = 1; cmd_valid = 1; cmd_write = 1;
    cmd_addr = 8'h11; cmd_wdata = 8'h22;
    rsp_ready = 0; prdata = 0; pready = 1;
    @(posedge pclk);
    for (int k = 0; k < 2; k++) begin
      @(negedge pclk);
      chk("rst_outs", {psel, penable, rsp_valid}, 3'b000);
      chk("rst_bus", {pwrite, paddr, pwdata}, 17'h0);
    end
    preset = 0; cmd_valid = 0; pready = 0;
    chk("rst_rsp", {rsp_err, rsp_rdata}, 9'h0);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    @(negedge pclk);
    chk("post_rst_idle", {psel, rsp_valid}, 2'b00);

    // zero-wait write
    xfer(1, 8'h01, 8'hA5, 0, 1, 8'h77, 0, 8'h00, 0, 3);
    // wait-state read
    xfer(0, 8'h02, 8'h00, 3, 4, 8'h5C, 0, 8'h5C, 0, 6);
    // response backpressure, then back-to-back command
    xfer(0, 8'h03, 8'h00, 0, 1, 8'h3C, 5, 8'h3C, 0, 3);
    xfer(1, 8'h04, 8'h9B, 2, 3, 8'hC3, 0, 8'h00, 0, 5);

`ifdef APB_TIMEOUT_EN
    xfer(0, 8'h05, 8'h00, 100, 4, 8'h00, 0, 8'h00, 1, 6);
    xfer(0, 8'h06, 8'h00, 3, 4, 8'hD2, 0, 8'hD2, 0, 6);
    xfer(0, 8'h07, 8'h00, 0, 1, 8'h81, 0, 8'h81, 0, 3);
`else
    xfer(0, 8'h05, 8'h00, 8, 9, 8'h6A, 0, 8'h6A, 0, 11);
`endif

    // reset during ACCESS with pready low
    chk("mid_cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h08;
    pready = 0;
    @(negedge pclk);
    cmd_valid = 0;
    @(negedge pclk);
    chk("mid_access", {psel, penable}, 2'b11);
    preset = 1;
    @(negedge pclk);
    preset = 0;
    chk("mid_rst_bus", {psel, penable}, 2'b00);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    pready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      chk("mid_no_rsp", {rsp_valid, psel}, 2'b00);
    end
    xfer(0, 8'h09, 8'h00, 1, 2, 8'h4E, 2, 8'h4E, 0, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
